qbu_rx_frame_router: RTL and testbench

- Frame-level demultiplexer for the 802.3br receive path, after the SMD/CRC checker.
- Classifies each incoming AXIS frame once, on its first beat, and steers the whole frame to one of four channels: 0 EMAC, 1 PMAC, 2 R, 3 V.
- Drops frames that are invalid, carry an unknown SMD, or belong to a disabled channel.
- Provides per-channel backpressure through a registered output stage, plus optional frame/drop statistics.

---
 rtl/qbu_rx_pkg.sv | 37 +++
 rtl/qbu_rx_smd_classify.sv | 40 ++++
 rtl/qbu_rx_frame_router.sv | 158 +++++++++++++++
 tb/tb_qbu_rx_frame_router.sv | 350 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/qbu_rx_pkg.sv
// Shared constants and types for the 802.3br receive frame router:
// SMD codes, CRC-type codes, channel indices and the router state enum.
package qbu_rx_pkg;

  localparam logic [7:0] SMD_E  = 8'hD5;
  localparam logic [7:0] SMD_R  = 8'h19;
  localparam logic [7:0] SMD_V  = 8'h07;
  localparam logic [7:0] SMD_S0 = 8'hE6;
  localparam logic [7:0] SMD_S1 = 8'h4C;
  localparam logic [7:0] SMD_S2 = 8'h7F;
  localparam logic [7:0] SMD_S3 = 8'hB3;
  localparam logic [7:0] SMD_C0 = 8'h61;
  localparam logic [7:0] SMD_C1 = 8'h52;
  localparam logic [7:0] SMD_C2 = 8'h9E;
  localparam logic [7:0] SMD_C3 = 8'h2A;

  localparam logic [1:0] CRC_OK  = 2'b01;
  localparam logic [1:0] MCRC_OK = 2'b10;

  localparam logic [1:0] CH_EMAC = 2'd0;
  localparam logic [1:0] CH_PMAC = 2'd1;
  localparam logic [1:0] CH_R    = 2'd2;
  localparam logic [1:0] CH_V    = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FWD  = 2'd1,
    ST_DROP = 2'd2
  } rx_state_e;

  // Start and continuation SMDs of preemptable (PMAC) fragments.
  function automatic logic is_pmac_smd(input logic [7:0] smd);
    return smd inside {SMD_S0, SMD_S1, SMD_S2, SMD_S3,
                       SMD_C0, SMD_C1, SMD_C2, SMD_C3};
  endfunction

endpackage

// File: rtl/qbu_rx_smd_classify.sv
// First-beat classifier: maps info_vld/SMD/CRC type to a channel and
// reports whether that channel may receive the frame.
module qbu_rx_smd_classify
  import qbu_rx_pkg::*;
(
  input  logic       info_vld,
  input  logic [7:0] smd,
  input  logic [1:0] crc_vld,
  input  logic       qbu_frm,
  input  logic [3:0] chan_en,
  output logic       route_ok,
  output logic [1:0] ch_idx
);

  logic known;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path infers a latch.
    known  = 1'b0;
    ch_idx = CH_EMAC;
    if (info_vld) begin
      if (smd == SMD_E && crc_vld == CRC_OK) begin
        known  = 1'b1;
        ch_idx = CH_EMAC;
      end else if (qbu_frm && is_pmac_smd(smd) &&
                   (crc_vld == CRC_OK || crc_vld == MCRC_OK)) begin
        known  = 1'b1;
        ch_idx = CH_PMAC;
      end else if (smd == SMD_R && crc_vld == CRC_OK) begin
        known  = 1'b1;
        ch_idx = CH_R;
      end else if (smd == SMD_V && crc_vld == CRC_OK) begin
        known  = 1'b1;
        ch_idx = CH_V;
      end
    end
    route_ok = known & chan_en[ch_idx];
  end

endmodule

// File: rtl/qbu_rx_frame_router.sv
// 802.3br receive frame router: steers whole AXIS frames to EMAC/PMAC/R/V
// through one shared output register. Statistics need QBU_RX_ROUTER_STATS_EN.
module qbu_rx_frame_router
  import qbu_rx_pkg::*;
#(
  parameter int DWIDTH = 8,
  parameter int CNT_W  = 16
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_qbu_frm,
  input  logic [3:0]              i_chan_en,
  input  logic [11:0]             i_data_len,
  input  logic [DWIDTH-1:0]       i_rx_axis_data,
  input  logic [15:0]             i_rx_axis_user,
  input  logic [DWIDTH/8-1:0]     i_rx_axis_keep,
  input  logic                    i_rx_axis_last,
  input  logic                    i_rx_axis_valid,
  output logic                    o_rx_axis_ready,
  output logic [4*DWIDTH-1:0]     o_ch_axis_data,
  output logic [4*16-1:0]         o_ch_axis_user,
  output logic [4*(DWIDTH/8)-1:0] o_ch_axis_keep,
  output logic [3:0]              o_ch_axis_last,
  output logic [3:0]              o_ch_axis_valid,
  input  logic [3:0]              i_ch_axis_ready,
  output logic [4*CNT_W-1:0]      o_frm_cnt,
  output logic [CNT_W-1:0]        o_drop_cnt
);

  localparam int KW = DWIDTH / 8;

  rx_state_e         state_q;
  logic [1:0]        sel_q;
  logic [11:0]       len_q;
  logic              out_valid_q;
  logic              out_last_q;
  logic [DWIDTH-1:0] out_data_q;
  logic [KW-1:0]     out_keep_q;
  logic [15:0]       out_user_q;

  logic        route_ok;
  logic [1:0]  cls_ch;
  logic        in_acc;
  logic        out_acc;
  logic        first_fwd;
  logic        load;
  logic [1:0]  beat_ch;
  logic [11:0] beat_len;
  logic [15:0] beat_user;
  logic        unused_user;

  qbu_rx_smd_classify u_classify (
    .info_vld (i_rx_axis_user[15]),
    .smd      (i_rx_axis_user[14:7]),
    .crc_vld  (i_rx_axis_user[4:3]),
    .qbu_frm  (i_qbu_frm),
    .chan_en  (i_chan_en),
    .route_ok (route_ok),
    .ch_idx   (cls_ch)
  );

  assign o_rx_axis_ready = ~i_rst & ((state_q == ST_DROP) | ~out_valid_q | i_ch_axis_ready[sel_q]);
  assign in_acc    = i_rx_axis_valid & o_rx_axis_ready;
  assign out_acc   = out_valid_q & i_ch_axis_ready[sel_q];
  assign first_fwd = in_acc & (state_q == ST_IDLE) & route_ok;
  assign load      = first_fwd | (in_acc & (state_q == ST_FWD));

  // On the first beat the classifier and the live length are used; later beats use the latched copies.
  assign beat_ch     = (state_q == ST_IDLE) ? cls_ch : sel_q;
  assign beat_len    = (state_q == ST_IDLE) ? i_data_len : len_q;
  assign beat_user   = (beat_ch == CH_PMAC) ? {3'b000, i_rx_axis_user[15:3]} : {4'b0000, beat_len};
  assign unused_user = ^i_rx_axis_user[2:0];

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q     <= ST_IDLE;
      sel_q       <= CH_EMAC;
      len_q       <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_data_q  <= '0;
      out_keep_q  <= '0;
      out_user_q  <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values, independent of statement order.
      if (load) begin
        out_valid_q <= 1'b1;
        out_last_q  <= i_rx_axis_last;
        out_data_q  <= i_rx_axis_data;
        out_keep_q  <= i_rx_axis_keep;
        out_user_q  <= beat_user;
      end else if (out_acc) begin
        out_valid_q <= 1'b0;
      end

      if (first_fwd) begin
        sel_q <= cls_ch;
        len_q <= i_data_len;
      end

      if (in_acc) begin
        unique case (state_q)
          ST_IDLE: begin
            if (i_rx_axis_last) state_q <= ST_IDLE;
            else if (route_ok)  state_q <= ST_FWD;
            else                state_q <= ST_DROP;
          end
          ST_FWD:  if (i_rx_axis_last) state_q <= ST_IDLE;
          ST_DROP: if (i_rx_axis_last) state_q <= ST_IDLE;
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  always_comb begin
    o_ch_axis_data  = '0;
    o_ch_axis_user  = '0;
    o_ch_axis_keep  = '0;
    o_ch_axis_last  = '0;
    o_ch_axis_valid = '0;
    if (out_valid_q) begin
      o_ch_axis_valid[sel_q]                     = 1'b1;
      o_ch_axis_last[sel_q]                      = out_last_q;
      o_ch_axis_data[int'(sel_q)*DWIDTH +: DWIDTH] = out_data_q;
      o_ch_axis_keep[int'(sel_q)*KW +: KW]       = out_keep_q;
      o_ch_axis_user[int'(sel_q)*16 +: 16]       = out_user_q;
    end
  end

`ifdef QBU_RX_ROUTER_STATS_EN
  logic [3:0][CNT_W-1:0] frm_cnt_q;
  logic [CNT_W-1:0]      drop_cnt_q;
  logic                  frm_done;
  logic                  drop_done;

  assign frm_done  = out_acc & out_last_q;
  assign drop_done = in_acc & i_rx_axis_last &
                     (((state_q == ST_IDLE) & ~route_ok) | (state_q == ST_DROP));

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      frm_cnt_q  <= '0;
      drop_cnt_q <= '0;
    end else begin
      if (frm_done && frm_cnt_q[sel_q] != '1) frm_cnt_q[sel_q] <= frm_cnt_q[sel_q] + 1'b1;
      if (drop_done && drop_cnt_q != '1)      drop_cnt_q <= drop_cnt_q + 1'b1;
    end
  end

  assign o_frm_cnt  = frm_cnt_q;
  assign o_drop_cnt = drop_cnt_q;
`else
  assign o_frm_cnt  = '0;
  assign o_drop_cnt = '0;
`endif

endmodule

// File: tb/tb_qbu_rx_frame_router.sv
// Randomized scoreboard bench for qbu_rx_frame_router: a frame-level reference
// model queues expected beats per channel; a negedge monitor pops and compares.
`timescale 1ns/1ps
module tb_qbu_rx_frame_router;

  localparam int DW   = 16;
  localparam int KW   = DW / 8;
  localparam int CW   = 5;
  localparam int MAXC = (1 << CW) - 1;

  logic              i_clk = 1'b0;
  logic              i_rst = 1'b1;
  logic              i_qbu_frm;
  logic [3:0]        i_chan_en;
  logic [11:0]       i_data_len;
  logic [DW-1:0]     i_rx_axis_data;
  logic [15:0]       i_rx_axis_user;
  logic [KW-1:0]     i_rx_axis_keep;
  logic              i_rx_axis_last;
  logic              i_rx_axis_valid;
  logic              o_rx_axis_ready;
  logic [4*DW-1:0]   o_ch_axis_data;
  logic [4*16-1:0]   o_ch_axis_user;
  logic [4*KW-1:0]   o_ch_axis_keep;
  logic [3:0]        o_ch_axis_last;
  logic [3:0]        o_ch_axis_valid;
  logic [3:0]        i_ch_axis_ready;
  logic [4*CW-1:0]   o_frm_cnt;
  logic [CW-1:0]     o_drop_cnt;

  qbu_rx_frame_router #(.DWIDTH(DW), .CNT_W(CW)) dut (
    .i_clk           (i_clk),
    .i_rst           (i_rst),
    .i_qbu_frm       (i_qbu_frm),
    .i_chan_en       (i_chan_en),
    .i_data_len      (i_data_len),
    .i_rx_axis_data  (i_rx_axis_data),
    .i_rx_axis_user  (i_rx_axis_user),
    .i_rx_axis_keep  (i_rx_axis_keep),
    .i_rx_axis_last  (i_rx_axis_last),
    .i_rx_axis_valid (i_rx_axis_valid),
    .o_rx_axis_ready (o_rx_axis_ready),
    .o_ch_axis_data  (o_ch_axis_data),
    .o_ch_axis_user  (o_ch_axis_user),
    .o_ch_axis_keep  (o_ch_axis_keep),
    .o_ch_axis_last  (o_ch_axis_last),
    .o_ch_axis_valid (o_ch_axis_valid),
    .i_ch_axis_ready (i_ch_axis_ready),
    .o_frm_cnt       (o_frm_cnt),
    .o_drop_cnt      (o_drop_cnt)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [DW-1:0] data;
    logic [KW-1:0] keep;
    logic          last;
    logic [15:0]   user;
  } beat_t;

  beat_t      exp_q[4][$];
  int         exp_frm[4];
  int         exp_drop;
  int         n_checks = 0;
  int         n_fail   = 0;
  bit         in_drop_body = 1'b0;
  bit         rdy_random   = 1'b0;
  logic [3:0] rdy_force    = 4'hF;
  logic [7:0] smd_tab [11] = '{8'hD5, 8'h19, 8'h07, 8'hE6, 8'h4C, 8'h7F,
                               8'hB3, 8'h61, 8'h52, 8'h9E, 8'h2A};

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic finish_test();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  endtask

  function automatic logic [15:0] mk_user(input logic info, input logic [7:0] smd,
                                          input logic [1:0] frag, input logic [1:0] crc);
    return {info, smd, frag, crc, 3'($urandom)};
  endfunction

  // Frame routing rules; -1 means the frame is dropped.
  function automatic int model_route(input logic [15:0] u, input logic qbu, input logic [3:0] en);
    logic [7:0] smd;
    logic [1:0] crc;
    int ch;
    smd = u[14:7];
    crc = u[4:3];
    ch  = -1;
    if (u[15]) begin
      if (smd == 8'hD5 && crc == 2'b01) ch = 0;
      else if (qbu && (smd inside {8'hE6, 8'h4C, 8'h7F, 8'hB3, 8'h61, 8'h52, 8'h9E, 8'h2A}) &&
               (crc inside {2'b01, 2'b10})) ch = 1;
      else if (smd == 8'h19 && crc == 2'b01) ch = 2;
      else if (smd == 8'h07 && crc == 2'b01) ch = 3;
    end
    if (ch >= 0 && !en[ch]) ch = -1;
    return ch;
  endfunction

  function automatic int sat(input int v);
    return (v > MAXC) ? MAXC : v;
  endfunction

  always @(posedge i_clk) begin
    #1;
    if (rdy_random) begin
      for (int c = 0; c < 4; c++) i_ch_axis_ready[c] = ($urandom_range(99) < 70);
    end else begin
      i_ch_axis_ready = rdy_force;
    end
  end

  // Monitor: a beat is transferred at the next posedge when valid and ready are both high here.
  always @(negedge i_clk) begin : monitor
    logic  idle_bad;
    beat_t e;
    if (!i_rst) begin
      idle_bad = 1'b0;
      for (int c = 0; c < 4; c++) begin
        if (!o_ch_axis_valid[c]) begin
          if (o_ch_axis_data[c*DW +: DW] != 0 || o_ch_axis_user[c*16 +: 16] != 0 ||
              o_ch_axis_keep[c*KW +: KW] != 0 || o_ch_axis_last[c] != 1'b0) idle_bad = 1'b1;
        end else if (i_ch_axis_ready[c]) begin
          if (exp_q[c].size() == 0) begin
            check($sformatf("unexpected beat ch%0d", c), 1, 0);
          end else begin
            e = exp_q[c].pop_front();
            check($sformatf("data ch%0d", c), o_ch_axis_data[c*DW +: DW], e.data);
            check($sformatf("keep ch%0d", c), o_ch_axis_keep[c*KW +: KW], e.keep);
            check($sformatf("last ch%0d", c), o_ch_axis_last[c], e.last);
            check($sformatf("user ch%0d", c), o_ch_axis_user[c*16 +: 16], e.user);
          end
        end
      end
      check("idle channels zero", idle_bad, 0);
      check("valid one-hot", $countones(o_ch_axis_valid) <= 1, 1);
      if (in_drop_body) check("drop ready", o_rx_axis_ready, 1);
      else if (|(o_ch_axis_valid & ~i_ch_axis_ready)) check("stall ready", o_rx_axis_ready, 0);
    end
  end

  task automatic send_frame(input logic [15:0] user0, input logic [11:0] len, input int nbeats,
                            input logic qbu, input logic [3:0] en, input int gap_pct, input int rst_at);
    int    route;
    int    waited;
    bit    acc;
    beat_t b_exp;
    route = -1;
    for (int b = 0; b < nbeats; b++) begin
      while (gap_pct > 0 && $urandom_range(99) < gap_pct) begin
        i_rx_axis_valid = 1'b0;
        @(posedge i_clk); #1;
      end
      i_rx_axis_valid = 1'b1;
      i_rx_axis_data  = DW'($urandom);
      i_rx_axis_keep  = KW'($urandom_range((1 << KW) - 1, 1));
      i_rx_axis_last  = (b == nbeats - 1);
      if (b == 0) begin
        i_rx_axis_user = user0;
        i_data_len     = len;
        i_qbu_frm      = qbu;
        i_chan_en      = en;
        route          = model_route(user0, qbu, en);
      end else begin
        i_rx_axis_user = 16'($urandom);
        i_data_len     = 12'($urandom);
        i_qbu_frm      = 1'($urandom);
        i_chan_en      = 4'($urandom);
      end
      acc    = 1'b0;
      waited = 0;
      while (!acc) begin
        @(negedge i_clk);
        if (rst_at == b + 1) begin
          i_rst = 1'b1;
          return;
        end
        acc = o_rx_axis_ready;
        @(posedge i_clk); #1;
        if (!acc) begin
          waited++;
          if (waited > 1000) begin
            check("input accept timeout", 0, 1);
            finish_test();
          end
        end
      end
      if (route >= 0) begin
        b_exp.data = i_rx_axis_data;
        b_exp.keep = i_rx_axis_keep;
        b_exp.last = i_rx_axis_last;
        b_exp.user = (route == 1) ? {3'b000, i_rx_axis_user[15:3]} : {4'b0000, len};
        exp_q[route].push_back(b_exp);
        if (i_rx_axis_last) exp_frm[route]++;
      end else if (i_rx_axis_last) begin
        exp_drop++;
      end
      in_drop_body = (route < 0) && !i_rx_axis_last;
    end
    i_rx_axis_valid = 1'b0;
  endtask

  task automatic check_counters(input string tag);
    for (int c = 0; c < 4; c++) begin
`ifdef QBU_RX_ROUTER_STATS_EN
      check($sformatf("%s frm_cnt%0d", tag, c), o_frm_cnt[c*CW +: CW], sat(exp_frm[c]));
`else
      check($sformatf("%s frm_cnt%0d", tag, c), o_frm_cnt[c*CW +: CW], 0);
`endif
    end
`ifdef QBU_RX_ROUTER_STATS_EN
    check({tag, " drop_cnt"}, o_drop_cnt, sat(exp_drop));
`else
    check({tag, " drop_cnt"}, o_drop_cnt, 0);
`endif
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while ((exp_q[0].size() + exp_q[1].size() + exp_q[2].size() + exp_q[3].size()) != 0 && n < 2000) begin
      @(posedge i_clk);
      n++;
    end
    check({tag, " drained"}, n < 2000, 1);
    repeat (2) @(posedge i_clk);
    #1;
    check_counters(tag);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " valid"}, o_ch_axis_valid, 0);
    check({tag, " data"},  o_ch_axis_data, 0);
    check({tag, " user"},  o_ch_axis_user, 0);
    check({tag, " keep"},  o_ch_axis_keep, 0);
    check({tag, " last"},  o_ch_axis_last, 0);
    check({tag, " rx_ready"}, o_rx_axis_ready, 0);
    check({tag, " frm_cnt"},  o_frm_cnt, 0);
    check({tag, " drop_cnt"}, o_drop_cnt, 0);
  endtask

  initial begin : watchdog
    #500000;
    check("global timeout", 0, 1);
    finish_test();
  end

  initial begin : stimulus
    logic [7:0]  smd;
    logic [1:0]  crc;
    logic        info;
    logic [3:0]  en;
    i_qbu_frm       = 1'b1;
    i_chan_en       = 4'hF;
    i_data_len      = '0;
    i_rx_axis_data  = '0;
    i_rx_axis_user  = '0;
    i_rx_axis_keep  = '0;
    i_rx_axis_last  = 1'b0;
    i_rx_axis_valid = 1'b0;
    i_ch_axis_ready = 4'hF;
    for (int c = 0; c < 4; c++) exp_frm[c] = 0;
    exp_drop = 0;

    repeat (3) @(posedge i_clk);
    #1;
    check_reset_outputs("reset");
    @(negedge i_clk);
    i_rst = 1'b0;
    @(posedge i_clk); #1;

    // Express frame, 4 beats, len 0x040.
    send_frame(mk_user(1'b1, 8'hD5, 2'b00, 2'b01), 12'h040, 4, 1'b1, 4'hF, 0, 0);
    drain("express");

    // PMAC with mCRC, preemption on, then off.
    send_frame(mk_user(1'b1, 8'hE6, 2'b01, 2'b10), 12'h055, 3, 1'b1, 4'hF, 0, 0);
    drain("pmac");
    send_frame(mk_user(1'b1, 8'hE6, 2'b01, 2'b10), 12'h055, 3, 1'b0, 4'hF, 0, 0);
    drain("pmac disabled");

    // R frame with channel 2 stalled for three cycles mid-frame.
    fork
      send_frame(mk_user(1'b1, 8'h19, 2'b00, 2'b01), 12'h123, 6, 1'b0, 4'hF, 0, 0);
      begin
        repeat (3) @(posedge i_clk);
        rdy_force = 4'b1011;
        repeat (3) @(posedge i_clk);
        rdy_force = 4'hF;
      end
    join
    drain("r stall");

    // Bad CRC on a V SMD, then a good V frame back to back.
    send_frame(mk_user(1'b1, 8'h07, 2'b00, 2'b00), 12'h010, 3, 1'b1, 4'hF, 0, 0);
    send_frame(mk_user(1'b1, 8'h07, 2'b00, 2'b01), 12'h011, 4, 1'b1, 4'hF, 0, 0);
    drain("bad crc then v");

    // Disabled EMAC channel, then single-beat V frames.
    send_frame(mk_user(1'b1, 8'hD5, 2'b00, 2'b01), 12'h020, 2, 1'b1, 4'b1110, 0, 0);
    send_frame(mk_user(1'b1, 8'h07, 2'b00, 2'b01), 12'h001, 1, 1'b1, 4'hF, 0, 0);
    send_frame(mk_user(1'b1, 8'h07, 2'b00, 2'b01), 12'h002, 1, 1'b1, 4'hF, 0, 0);
    send_frame(mk_user(1'b1, 8'h19, 2'b00, 2'b01), 12'h003, 2, 1'b1, 4'hF, 0, 0);
    drain("chan_en and single beat");

    // Reset during beat 2 of a 5-beat frame.
    send_frame(mk_user(1'b1, 8'hD5, 2'b00, 2'b01), 12'h050, 5, 1'b1, 4'hF, 0, 2);
    #1;
    check_reset_outputs("mid-frame reset");
    for (int c = 0; c < 4; c++) begin
      exp_q[c].delete();
      exp_frm[c] = 0;
    end
    exp_drop        = 0;
    in_drop_body    = 1'b0;
    i_rx_axis_valid = 1'b0;
    repeat (2) @(posedge i_clk);
    @(negedge i_clk);
    i_rst = 1'b0;
    @(posedge i_clk); #1;
    send_frame(mk_user(1'b1, 8'h19, 2'b00, 2'b01), 12'h0AB, 3, 1'b1, 4'hF, 0, 0);
    drain("after reset");

    // Random traffic with random backpressure; counters saturate along the way.
    rdy_random = 1'b1;
    for (int f = 0; f < 400; f++) begin
      smd  = ($urandom_range(9) == 0) ? 8'($urandom) : smd_tab[$urandom_range(10)];
      info = ($urandom_range(9) != 0);
      crc  = ($urandom_range(3) != 0) ? (($urandom_range(1) == 1) ? 2'b01 : 2'b10) : 2'($urandom);
      en   = ($urandom_range(99) < 80) ? 4'hF : 4'($urandom);
      send_frame(mk_user(info, smd, 2'($urandom), crc), 12'($urandom),
                 $urandom_range(6, 1), 1'($urandom_range(3) != 0), en, 20, 0);
    end
    rdy_random = 1'b0;
    drain("random");

    finish_test();
  end

endmodule
